// File: rtl/spi_sram_responder.sv
// SPI mode-0 target emulating a serial SRAM (READ 0x03 / WRITE 0x02,
// 16-bit address, auto-increment), with pins oversampled in clk domain.
module spi_sram_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic busy,
    output logic cmd_err
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WRITE, READ, IGNORE
    } state_t;

    logic [2:0] sclk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;

    state_t        state, state_n;
    logic [7:0]    rx, rx_n;
    logic [2:0]    bcnt, bcnt_n;
    logic          is_rd, is_rd_n;
    logic          ahi, ahi_n;
    logic [7:0]    addr_hi, addr_hi_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [7:0]    tx, tx_n;
    logic          miso_n;
    logic          err_n;
    logic          we;

    logic [7:0] mem [DEPTH_BYTES];

    logic       rise, fall, cs_hi, byte_done;
    logic [7:0] rx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q   <= {cs_q[0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign fall      = ~sclk_q[1] & sclk_q[2];
    assign cs_hi     = cs_q[1];
    assign rx_shift  = {rx[6:0], mosi_q[1]};
    assign byte_done = rise && (bcnt == 3'd7);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n   = state;
        rx_n      = rx;
        bcnt_n    = bcnt;
        is_rd_n   = is_rd;
        ahi_n     = ahi;
        addr_hi_n = addr_hi;
        ptr_n     = ptr;
        tx_n      = tx;
        miso_n    = spi_miso;
        err_n     = 1'b0;
        we        = 1'b0;
        if (cs_hi) begin
            // Deselect beats any same-cycle rise: partial bytes are dropped.
            state_n = IDLE;
            miso_n  = 1'b0;
        end else if (state == IDLE) begin
            state_n = CMD;
            bcnt_n  = 3'd0;
            ahi_n   = 1'b0;
        end else begin
            if (rise) begin
                rx_n   = rx_shift;
                bcnt_n = bcnt + 3'd1;
            end
            case (state)
                CMD: begin
                    if (byte_done) begin
                        if (rx_shift == 8'h02 || rx_shift == 8'h03) begin
                            state_n = ADDR;
                            is_rd_n = rx_shift[0];
                        end else begin
                            state_n = IGNORE;
                            err_n   = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        if (!ahi) begin
                            addr_hi_n = rx_shift;
                            ahi_n     = 1'b1;
                        end else begin
                            ptr_n   = AW'({addr_hi, rx_shift});
                            state_n = is_rd ? READ : WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (byte_done) begin
                        we    = 1'b1;
                        ptr_n = ptr + AW'(1);
                    end
                end
                READ: begin
                    // bcnt counts rises, so at a fall it names the next bit.
                    if (fall) begin
                        if (bcnt == 3'd0) begin
                            tx_n   = mem[ptr];
                            miso_n = mem[ptr][7];
                            ptr_n  = ptr + AW'(1);
                        end else begin
                            miso_n = tx[3'd7 - bcnt];
                        end
                    end
                end
                default: miso_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rx       <= 8'h00;
            bcnt     <= 3'd0;
            is_rd    <= 1'b0;
            ahi      <= 1'b0;
            addr_hi  <= 8'h00;
            ptr      <= '0;
            tx       <= 8'h00;
            spi_miso <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state    <= state_n;
            rx       <= rx_n;
            bcnt     <= bcnt_n;
            is_rd    <= is_rd_n;
            ahi      <= ahi_n;
            addr_hi  <= addr_hi_n;
            ptr      <= ptr_n;
            tx       <= tx_n;
            spi_miso <= miso_n;
            cmd_err  <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[ptr] <= rx_shift;
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Randomized bench for spi_sram_responder against a byte-array model
// of the serial SRAM (256-byte configuration).
module tb_spi_sram_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_clk = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic busy;
    logic cmd_err;

    int n_chk = 0;
    int n_err = 0;
    int err_pulses = 0;
    int hp = 4;

    logic [7:0] ref_mem [256];
    logic [7:0] wbuf [256];
    logic [7:0] rbuf [256];

    spi_sram_responder #(.DEPTH_BYTES(256)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi_clk(spi_clk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .busy(busy),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_err) err_pulses++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (hp) @(negedge clk);
        spi_clk = 1'b1;
        repeat (hp) @(negedge clk);
        r = spi_miso;
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], x);
            r[i] = x;
        end
    endtask

    task automatic cs_start();
        @(negedge clk);
        spi_cs_n = 1'b0;
        @(negedge clk);
        chk("busy_pre", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("busy_on", {31'd0, busy}, 32'd1);
    endtask

    task automatic cs_end();
        repeat (hp) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("busy_off", {31'd0, busy}, 32'd0);
    endtask

    task automatic send_hdr(input logic [7:0] c, input logic [15:0] a,
                            output logic [7:0] ored);
        logic [7:0] r;
        ored = 8'h00;
        spi_byte(c, r);       ored |= r;
        spi_byte(a[15:8], r); ored |= r;
        spi_byte(a[7:0], r);  ored |= r;
    endtask

    task automatic mem_write(input logic [15:0] a, input int n);
        logic [7:0] o, r;
        cs_start();
        send_hdr(8'h02, a, o);
        for (int i = 0; i < n; i++) begin
            spi_byte(wbuf[i], r);
            o |= r;
            ref_mem[(int'(a) + i) % 256] = wbuf[i];
        end
        cs_end();
        chk("miso_wr_zero", {24'd0, o}, 32'd0);
    endtask

    task automatic mem_read(input logic [15:0] a, input int n);
        logic [7:0] o;
        cs_start();
        send_hdr(8'h03, a, o);
        chk("miso_hdr_zero", {24'd0, o}, 32'd0);
        for (int i = 0; i < n; i++) spi_byte(8'h00, rbuf[i]);
        cs_end();
    endtask

    function automatic logic [31:0] rword();
        return {rbuf[0], rbuf[1], rbuf[2], rbuf[3]};
    endfunction

    initial begin
        logic [7:0] o, r;
        logic x;
        int a, n;
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        hp = 2;
        for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
        mem_write(16'h0000, 256);

        hp = 4;
        {wbuf[0], wbuf[1], wbuf[2], wbuf[3]} = 32'hDEADBEEF;
        mem_write(16'h0010, 4);
        mem_read(16'h0010, 4);
        chk("wr_rd_word", rword(), 32'hDEADBEEF);
        chk("no_cmd_err", err_pulses, 0);

        cs_start();
        o = 8'h00;
        spi_byte(8'h05, r);
        o |= r;
        chk("bad_cmd_pulse", err_pulses, 1);
        for (int i = 0; i < 24; i++) begin
            spi_bit(1'($urandom), x);
            o[0] |= x;
        end
        cs_end();
        chk("bad_cmd_miso", {24'd0, o}, 32'd0);
        chk("bad_cmd_once", err_pulses, 1);
        mem_read(16'h0010, 4);
        chk("after_bad_word", rword(), 32'hDEADBEEF);

        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        mem_write(16'h00FF, 2);
        mem_read(16'h00FF, 2);
        chk("wrap_pair", {16'd0, rbuf[0], rbuf[1]}, 32'h1122);
        mem_read(16'h0000, 1);
        chk("wrap_low", {24'd0, rbuf[0]}, 32'h22);
        mem_read(16'h01FF, 1);
        chk("alias_1ff", {24'd0, rbuf[0]}, 32'h11);

        wbuf[0] = 8'hAA;
        mem_write(16'h0020, 1);
        cs_start();
        send_hdr(8'h02, 16'h0020, o);
        for (int i = 0; i < 5; i++) spi_bit(1'(i % 2), x);
        cs_end();
        mem_read(16'h0020, 1);
        chk("abort_keep", {24'd0, rbuf[0]}, 32'hAA);

        cs_start();
        send_hdr(8'h03, 16'h0010, o);
        spi_byte(8'h00, r);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, x);
        spi_clk = 1'b1;
        repeat (hp) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        spi_clk = 1'b0;
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mem_read(16'h0010, 4);
        chk("rst_reread", rword(), 32'hDEADBEEF);

        hp = 2;
        {wbuf[0], wbuf[1], wbuf[2], wbuf[3]} = 32'h12345678;
        mem_write(16'(4 * 4), 4);
        mem_read(16'(4 * 4), 4);
        chk("master_word", rword(), 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            mem_read(16'h0010 + 16'(i), 1);
            chk("master_byte", {24'd0, rbuf[0]}, {24'd0, ref_mem[16 + i]});
        end

        for (int t = 0; t < 16; t++) begin
            hp = 2 + int'($urandom_range(0, 2));
            a = int'($urandom_range(0, 65535));
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            mem_write(16'(a), n);
            a = int'($urandom_range(0, 65535));
            n = int'($urandom_range(1, 6));
            mem_read(16'(a), n);
            for (int i = 0; i < n; i++)
                chk("rand_rd", {24'd0, rbuf[i]},
                    {24'd0, ref_mem[(a + i) % 256]});
        end
        chk("final_cmd_err", err_pulses, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
